// File: rtl/ex_alu_pipe_pkg.sv
// Shared op codes, FSM states and helpers for the registered EX-stage ALU.
package ex_alu_pipe_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SLLV = 4'b0011,
    OP_SRAV = 4'b0100,
    OP_SRLV = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SLL  = 4'b0111,
    OP_XOR  = 4'b1000,
    OP_NOR  = 4'b1001,
    OP_SLT  = 4'b1010,
    OP_SLTU = 4'b1011,
    OP_MUL  = 4'b1100,
    OP_DIVU = 4'b1101,
    OP_REMU = 4'b1110,
    OP_PASS = 4'b1111
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    MD_MUL  = 2'd0,
    MD_DIVU = 2'd1,
    MD_REMU = 2'd2
  } md_op_e;

  function automatic logic is_md(input logic [3:0] sel);
    return (sel == OP_MUL) || (sel == OP_DIVU) || (sel == OP_REMU);
  endfunction

  function automatic md_op_e to_md_op(input logic [3:0] sel);
    if (sel == OP_MUL) return MD_MUL;
    if (sel == OP_DIVU) return MD_DIVU;
    return MD_REMU;
  endfunction

endpackage

// File: rtl/ex_alu_pipe_muldiv_iter.sv
// Radix-2 iterative unit: shift-add multiply (low DWL bits) and restoring unsigned divide.
// One step per edge while run is high; done flags the step that produces the final result.
module muldiv_iter
  import ex_alu_pipe_pkg::*;
#(
  parameter int DWL = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           run,
  input  md_op_e         op,
  input  logic [DWL-1:0] a,
  input  logic [DWL-1:0] b,
  output logic           done,
  output logic [DWL-1:0] result
);

  localparam int CW = $clog2(DWL);

  // acc: product accumulator or partial remainder.
  // opa: shifting multiplicand, or dividend shifting out / quotient shifting in.
  // opb: shifting multiplier, or divisor.
  md_op_e         op_q;
  logic [DWL-1:0] acc, opa, opb;
  logic [DWL-1:0] acc_nx, opa_nx, opb_nx;
  logic [CW-1:0]  count;
  logic [DWL:0]   trial;
  logic           fits;

  always_comb begin
    acc_nx = acc;
    opa_nx = opa;
    opb_nx = opb;
    trial  = {acc, opa[DWL-1]};
    fits   = trial >= {1'b0, opb};
    if (op_q == MD_MUL) begin
      if (opb[0]) acc_nx = acc + opa;
      opa_nx = opa << 1;
      opb_nx = opb >> 1;
    end else begin
      // A zero divisor always "fits": quotient fills with ones, remainder ends as the dividend.
      acc_nx = fits ? (trial[DWL-1:0] - opb) : trial[DWL-1:0];
      opa_nx = {opa[DWL-2:0], fits};
    end
  end

  assign done   = run && (count == '0);
  assign result = (op_q == MD_DIVU) ? opa_nx : acc_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= MD_MUL;
      acc   <= '0;
      opa   <= '0;
      opb   <= '0;
      count <= '0;
    end else if (start) begin
      op_q  <= op;
      acc   <= '0;
      opa   <= a;
      opb   <= b;
      count <= CW'(DWL - 1);
    end else if (run) begin
      acc <= acc_nx;
      opa <= opa_nx;
      opb <= opb_nx;
      if (count != '0) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/ex_alu_pipe.sv
// Registered EX-stage ALU: 1-cycle logic/arith/shift ops plus iterative MUL/DIVU/REMU.
// Handshake: an op is accepted on a rising edge where in_valid & in_ready & ~flush; out_valid pulses once per result.
module ex_alu_pipe
  import ex_alu_pipe_pkg::*;
#(
  parameter int DWL   = 32,
  parameter bit MD_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [DWL-1:0] R1,
  input  logic signed [DWL-1:0] R2,
  input  logic [4:0]            shamt,
  input  logic [3:0]            sel,
  output logic                  out_valid,
  output logic signed [DWL-1:0] ADO,
  output logic                  zero_flg
);

  localparam int SHW = $clog2(DWL);

  state_e         state, state_nx;
  op_e            op;
  logic           accept, md_sel, md_start, md_run, md_done;
  logic [SHW-1:0] sh;
  logic [DWL-1:0] alu_res, md_result;

  assign op       = op_e'(sel);
  assign sh       = R1[SHW-1:0];
  assign in_ready = (state == ST_IDLE) & rst_n;
  assign accept   = in_valid & in_ready & ~flush;
  assign md_sel   = MD_EN && is_md(sel);
  assign md_start = accept & md_sel;
  assign md_run   = (state == ST_BUSY) & ~flush;

  // With MD_EN=0 the multi-cycle codes fall through to PASS here.
  always_comb begin
    alu_res = R1;
    case (op)
      OP_AND:  alu_res = R1 & R2;
      OP_OR:   alu_res = R1 | R2;
      OP_ADD:  alu_res = R1 + R2;
      OP_SUB:  alu_res = R1 - R2;
      OP_SLL:  alu_res = R2 << shamt;
      OP_SLLV: alu_res = R2 << sh;
      OP_SRAV: alu_res = $signed(R2) >>> sh;
      OP_SRLV: alu_res = $unsigned(R2) >> sh;
      OP_XOR:  alu_res = R1 ^ R2;
      OP_NOR:  alu_res = ~(R1 | R2);
      OP_SLT:  alu_res = {{(DWL-1){1'b0}}, ($signed(R1) < $signed(R2))};
      OP_SLTU: alu_res = {{(DWL-1){1'b0}}, ($unsigned(R1) < $unsigned(R2))};
      default: alu_res = R1;
    endcase
  end

  generate
    if (MD_EN) begin : g_md
      muldiv_iter #(.DWL(DWL)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .run    (md_run),
        .op     (to_md_op(sel)),
        .a      (R1),
        .b      (R2),
        .done   (md_done),
        .result (md_result)
      );
    end else begin : g_no_md
      assign md_done   = 1'b0;
      assign md_result = '0;
    end
  endgenerate

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (md_start) state_nx = ST_BUSY;
        ST_BUSY: if (md_done) state_nx = ST_IDLE;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Results hold between pulses; a flush drops whatever would have completed on this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      ADO       <= '0;
      zero_flg  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (!flush) begin
        if (accept && !md_sel) begin
          out_valid <= 1'b1;
          ADO       <= alu_res;
          zero_flg  <= (alu_res == '0);
        end else if (md_done) begin
          out_valid <= 1'b1;
          ADO       <= md_result;
          zero_flg  <= (md_result == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_ex_alu_pipe.sv
// Directed bench for ex_alu_pipe: driver pushes hand-computed results, a negedge monitor pops and compares.
module tb_ex_alu_pipe;
  import ex_alu_pipe_pkg::*;

  localparam int DWL = 32;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  flush = 1'b0;
  logic                  in_valid = 1'b0;
  logic [DWL-1:0]        r1 = '0;
  logic [DWL-1:0]        r2 = '0;
  logic [4:0]            shamt = '0;
  logic [3:0]            sel = '0;
  logic                  in_ready, out_valid, zero_flg;
  logic signed [DWL-1:0] ado;

  ex_alu_pipe #(.DWL(DWL), .MD_EN(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .R1        (r1),
    .R2        (r2),
    .shamt     (shamt),
    .sel       (sel),
    .out_valid (out_valid),
    .ADO       (ado),
    .zero_flg  (zero_flg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  logic [DWL-1:0] exp_q[$];
  int             when_q[$];
  string          tag_q[$];
  int             n_vec = 0;
  int             n_fail = 0;

  task automatic check(input string name, input logic [DWL-1:0] act, input logic [DWL-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (rst_n && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_out: got out_valid with ADO=0x%08h, expected none (cycle %0d)", ado, cyc);
      end else begin
        logic [DWL-1:0] e;
        int             w;
        string          t;
        e = exp_q.pop_front();
        w = when_q.pop_front();
        t = tag_q.pop_front();
        check({t, "_ado"}, ado, e);
        check({t, "_zero_flg"}, {31'd0, zero_flg}, {31'd0, (e == '0)});
        check({t, "_cycle"}, cyc, w);
      end
    end
  end

  // driver: called just after a negedge; returns at the negedge after the accept edge.
  // edges = rising edges between accept and the edge that registers the result.
  task automatic issue(input string tag, input logic [3:0] s, input logic [DWL-1:0] a,
                       input logic [DWL-1:0] b, input logic [4:0] sh,
                       input logic [DWL-1:0] e, input int edges, input bit expect_out);
    int n;
    sel = s; r1 = a; r2 = b; shamt = sh; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s_accept: in_ready stayed 0, expected 1", tag);
    end else if (expect_out) begin
      exp_q.push_back(e);
      when_q.push_back(cyc + 1 + edges);
      tag_q.push_back(tag);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_ado", ado, 32'd0);
    check("rst_zero_flg", {31'd0, zero_flg}, 32'd0);
    check("rst_in_ready_low", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready_high", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    // back-to-back single-cycle ops
    issue("add",  OP_ADD,  32'd5,        32'hFFFFFFF9, 5'd0,  32'hFFFFFFFE, 0, 1'b1);
    issue("sub",  OP_SUB,  32'd9,        32'd9,        5'd0,  32'h00000000, 0, 1'b1);
    issue("and",  OP_AND,  32'h0000F0F0, 32'h0000FF00, 5'd0,  32'h0000F000, 0, 1'b1);
    issue("or",   OP_OR,   32'h0000F0F0, 32'h0000FF00, 5'd0,  32'h0000FFF0, 0, 1'b1);
    issue("xor",  OP_XOR,  32'h0000F0F0, 32'h0000FF00, 5'd0,  32'h00000FF0, 0, 1'b1);
    issue("nor",  OP_NOR,  32'h0000F0F0, 32'h0000FF00, 5'd0,  32'hFFFF000F, 0, 1'b1);
    issue("sll",  OP_SLL,  32'd0,        32'd1,        5'd31, 32'h80000000, 0, 1'b1);
    issue("sllv", OP_SLLV, 32'h00000024, 32'd3,        5'd0,  32'h00000030, 0, 1'b1);
    issue("srav", OP_SRAV, 32'd4,        32'h80000000, 5'd0,  32'hF8000000, 0, 1'b1);
    issue("srlv", OP_SRLV, 32'd4,        32'h80000000, 5'd0,  32'h08000000, 0, 1'b1);
    issue("slt",  OP_SLT,  32'hFFFFFFFF, 32'd1,        5'd0,  32'h00000001, 0, 1'b1);
    issue("sltu", OP_SLTU, 32'hFFFFFFFF, 32'd1,        5'd0,  32'h00000000, 0, 1'b1);
    issue("pass", OP_PASS, 32'hDEADBEEF, 32'd7,        5'd0,  32'hDEADBEEF, 0, 1'b1);
    drain();

    // MUL: stall length, result timing, then ADD in the out_valid cycle
    issue("mul", OP_MUL, 32'h00001234, 32'h00000010, 5'd0, 32'h00012340, 32, 1'b1);
    n = 0;
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("mul_stall_cycles", n, 32);
    issue("add_after_mul", OP_ADD, 32'd2, 32'd3, 5'd0, 32'd5, 0, 1'b1);
    issue("mul_ones", OP_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 32'h00000001, 32, 1'b1);
    issue("divu",     OP_DIVU, 32'd100,      32'd7,        5'd0, 32'd14,       32, 1'b1);
    issue("remu",     OP_REMU, 32'd100,      32'd7,        5'd0, 32'd2,        32, 1'b1);
    issue("divu_z",   OP_DIVU, 32'd5,        32'd0,        5'd0, 32'hFFFFFFFF, 32, 1'b1);
    issue("remu_z",   OP_REMU, 32'd5,        32'd0,        5'd0, 32'd5,        32, 1'b1);
    drain();

    // flush in the 10th busy cycle discards the multiply
    issue("add_77", OP_ADD, 32'h00000070, 32'h00000007, 5'd0, 32'h00000077, 0, 1'b1);
    drain();
    issue("mul_flushed", OP_MUL, 32'd3, 32'd4, 5'd0, 32'd12, 32, 1'b0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_ado_hold", ado, 32'h00000077);
    repeat (40) @(negedge clk);
    check("flush_ado_later", ado, 32'h00000077);

    // asynchronous reset in the middle of a divide
    issue("divu_reset", OP_DIVU, 32'd100, 32'd7, 5'd0, 32'd14, 32, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ado", ado, 32'd0);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_zero_flg", {31'd0, zero_flg}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue("add_post_rst", OP_ADD, 32'd1, 32'd1, 5'd0, 32'd2, 0, 1'b1);
    drain();
    repeat (40) @(negedge clk);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $fatal(1, "timeout");
  end

endmodule
